// File: rtl/multdiv_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, exception codes,
// FSM encoding and default parameters.
package multdiv_sequencer_pkg;

    localparam int MD_CYCLES_DEF   = 34;
    localparam int RSTATUS_REG_DEF = 30;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_SLL  = 5'b00100;
    localparam logic [4:0] OP_SRA  = 5'b00101;
    localparam logic [4:0] OP_MULT = 5'b00110;
    localparam logic [4:0] OP_DIV  = 5'b00111;

    localparam logic [2:0] EXC_NONE = 3'd0;
    localparam logic [2:0] EXC_ADD  = 3'd1;
    localparam logic [2:0] EXC_SUB  = 3'd3;
    localparam logic [2:0] EXC_MULT = 3'd4;
    localparam logic [2:0] EXC_DIV  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_md_op(input logic [4:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // Overflow only means something for the arithmetic ops; logic/shift/reserved ignore it.
    function automatic logic [2:0] exc_code(input logic [4:0] op, input logic ovf);
        logic [2:0] code;
        code = EXC_NONE;
        if (ovf) begin
            case (op)
                OP_ADD:  code = EXC_ADD;
                OP_SUB:  code = EXC_SUB;
                OP_MULT: code = EXC_MULT;
                OP_DIV:  code = EXC_DIV;
                default: code = EXC_NONE;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/multdiv_sequencer_cycle_counter.sv
// Down-counter that times how long mult/div operands are held at the ALU.
module md_cycle_counter #(
    parameter int W = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences ops from the D/X stage onto a shared ALU: single-cycle ops stream at
// one per cycle, mult/div hold the ALU operands for MD_CYCLES cycles.
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int MD_CYCLES   = MD_CYCLES_DEF,
    parameter int RSTATUS_REG = RSTATUS_REG_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_opcode,
    input  logic [4:0]  in_shamt,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_flush,
    output logic [4:0]  alu_opcode,
    output logic [4:0]  alu_shamt,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    output logic        out_valid,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic [2:0]  out_exc,
    output state_e      fsm_state
);

    localparam int CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

    // Handshake: an op transfers on a rising edge where in_valid && in_ready are both
    // high and in_flush is low; in_ready depends only on state, never on in_valid.
    state_e      state_q, state_d;
    logic        accept;
    logic        cnt_load, cnt_dec, cnt_zero, md_capture;
    logic        single_pend;
    logic [4:0]  op_rd;
    logic        cap_valid;
    logic [31:0] cap_result;
    logic [4:0]  cap_rd;
    logic [2:0]  cap_exc;

    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid && in_ready && !in_flush;
    assign fsm_state = state_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        md_capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && is_md_op(in_opcode)) begin
                    state_d  = BUSY;
                    cnt_load = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_zero) begin
                    md_capture = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (in_flush) begin
            state_d    = IDLE;
            cnt_load   = 1'b0;
            cnt_dec    = 1'b0;
            md_capture = 1'b0;
        end
    end

    md_cycle_counter #(.W(CNT_W)) u_counter (
        .clock      (clock),
        .reset      (reset),
        .clear      (in_flush),
        .load       (cnt_load),
        .load_value (CNT_W'(MD_CYCLES - 1)),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_opcode  <= '0;
            alu_shamt   <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            op_rd       <= '0;
            single_pend <= 1'b0;
        end else begin
            single_pend <= accept && !is_md_op(in_opcode);
            if (accept) begin
                alu_opcode <= in_opcode;
                alu_shamt  <= in_shamt;
                alu_a      <= in_a;
                alu_b      <= in_b;
                op_rd      <= in_rd;
            end
        end
    end

    // Capture stage: ALU output for the op currently presented on alu_*.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cap_valid  <= 1'b0;
            cap_result <= '0;
            cap_rd     <= '0;
            cap_exc    <= '0;
        end else begin
            cap_valid <= !in_flush && (single_pend || md_capture);
            if (!in_flush && (single_pend || md_capture)) begin
                cap_result <= alu_result;
                cap_rd     <= op_rd;
                cap_exc    <= exc_code(alu_opcode, alu_overflow);
            end
        end
    end

    // Exceptions are redirected to the status register as a small code.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_exc    <= '0;
        end else begin
            out_valid <= cap_valid && !in_flush;
            if (cap_valid && !in_flush) begin
                out_exc <= cap_exc;
                if (cap_exc != EXC_NONE) begin
                    out_rd     <= 5'(RSTATUS_REG);
                    out_result <= {29'd0, cap_exc};
                end else begin
                    out_rd     <= cap_rd;
                    out_result <= cap_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer with a behavioural ALU attached.
module tb_multdiv_sequencer;
    import multdiv_sequencer_pkg::*;

    localparam int MD = 34;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_opcode = '0;
    logic [4:0]  in_shamt = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_flush = 1'b0;
    logic [4:0]  alu_opcode, alu_shamt;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        out_valid;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic [2:0]  out_exc;
    state_e      fsm_state;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [71:0] exp_q[$];

    multdiv_sequencer #(.MD_CYCLES(MD), .RSTATUS_REG(30)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_shamt(in_shamt), .in_rd(in_rd), .in_a(in_a), .in_b(in_b),
        .in_flush(in_flush), .alu_opcode(alu_opcode), .alu_shamt(alu_shamt),
        .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_result(out_result), .out_rd(out_rd), .out_exc(out_exc),
        .fsm_state(fsm_state)
    );

    // clock / reset block
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // behavioural ALU (environment, combinational)
    logic signed [63:0] prod;
    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        prod         = '0;
        case (alu_opcode)
            5'b00000: begin
                alu_result   = alu_a + alu_b;
                alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            5'b00001: begin
                alu_result   = alu_a - alu_b;
                alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            5'b00010: alu_result = alu_a & alu_b;
            5'b00011: alu_result = alu_a | alu_b;
            5'b00100: alu_result = alu_a << alu_shamt;
            5'b00101: alu_result = $signed(alu_a) >>> alu_shamt;
            5'b00110: begin
                prod         = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});
                alu_result   = prod[31:0];
                alu_overflow = (prod[63:32] != {32{prod[31]}});
            end
            5'b00111: begin
                if (alu_b == 32'd0) alu_overflow = 1'b1;
                else alu_result = $signed(alu_a) / $signed(alu_b);
            end
            default: begin
                alu_result   = alu_a ^ alu_b;
                alu_overflow = 1'b1;
            end
        endcase
    end

    // scoreboard: entries are {expected cycle, result, rd, exc}
    logic [71:0] e;
    always @(negedge clock) begin
        if (!reset && out_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out_valid cyc=%0d rd=%0d res=%h exc=%0d", cyc, out_rd, out_result, out_exc);
            end else begin
                e = exp_q.pop_front();
                if ({cyc, out_result, out_rd, out_exc} !== e) begin
                    bad++;
                    $display("FAIL writeback got cyc=%0d res=%h rd=%0d exc=%0d exp cyc=%0d res=%h rd=%0d exc=%0d",
                             cyc, out_result, out_rd, out_exc, e[71:40], e[39:8], e[7:3], e[2:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, want);
        end
    endtask

    // driver: returns at accept edge + 1
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [4:0] rd, input logic [31:0] er,
                        input logic [4:0] erd, input logic [2:0] ee, input bit push);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clock); #1;
            guard++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL ready_timeout in_ready=%0d exp=1", in_ready);
        end
        in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b; in_shamt = sh; in_rd = rd;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = is_md_op(op) ? MD + 1 : 2;
        if (push) exp_q.push_back({32'(cyc + lat), er, erd, ee});
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clock); #1;
            guard++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b;
        logic [4:0]  sh, rd;
        logic [31:0] er;
        logic [4:0]  erd;
        logic [2:0]  ee;
    } vec_t;
    vec_t vecs[12];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int unstable;
        vecs[0]  = '{5'b00000, 32'h7FFFFFFF, 32'h1,      5'd0,  5'd5,  32'd1,        5'd30, 3'd1};
        vecs[1]  = '{5'b00001, 32'd10,       32'd3,      5'd0,  5'd4,  32'd7,        5'd4,  3'd0};
        vecs[2]  = '{5'b00010, 32'hF0F0,     32'hFF00,   5'd0,  5'd6,  32'hF000,     5'd6,  3'd0};
        vecs[3]  = '{5'b00011, 32'h0F00,     32'h00F0,   5'd0,  5'd7,  32'h0FF0,     5'd7,  3'd0};
        vecs[4]  = '{5'b00100, 32'h1,        32'h0,      5'd31, 5'd9,  32'h80000000, 5'd9,  3'd0};
        vecs[5]  = '{5'b00101, 32'h80000000, 32'h0,      5'd4,  5'd10, 32'hF8000000, 5'd10, 3'd0};
        vecs[6]  = '{5'b00001, 32'h80000000, 32'h1,      5'd0,  5'd11, 32'd3,        5'd30, 3'd3};
        vecs[7]  = '{5'b01000, 32'h000000FF, 32'h0000000F, 5'd0, 5'd12, 32'h000000F0, 5'd12, 3'd0};
        vecs[8]  = '{5'b00111, 32'd5,        32'd0,      5'd0,  5'd2,  32'd5,        5'd30, 3'd5};
        vecs[9]  = '{5'b00110, 32'h10000,    32'h10000,  5'd0,  5'd3,  32'd4,        5'd30, 3'd4};
        vecs[10] = '{5'b00111, 32'd100,      32'd7,      5'd0,  5'd13, 32'd14,       5'd13, 3'd0};
        vecs[11] = '{5'b00000, 32'd20,       32'd22,     5'd0,  5'd1,  32'd42,       5'd1,  3'd0};

        // reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_out_exc", 32'(out_exc), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_op", 32'({alu_opcode, alu_shamt}), 32'd0);
        reset = 1'b0;

        // table: first accept lands on the first edge after release; singles back-to-back
        for (int i = 0; i < 12; i++)
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].rd,
                 vecs[i].er, vecs[i].erd, vecs[i].ee, 1'b1);
        drain();

        // mult 6*7: in_ready low MD+1 cycles with operands held
        send(5'b00110, 32'd6, 32'd7, 5'd0, 5'd8, 32'd42, 5'd8, 3'd0, 1'b1);
        check("mult_state_busy", 32'(fsm_state), 32'(BUSY));
        n = 0; unstable = 0;
        while (!in_ready && n < 200) begin
            if (alu_a !== 32'd6 || alu_b !== 32'd7 || alu_opcode !== 5'b00110) unstable++;
            n++;
            @(posedge clock); #1;
        end
        check("mult_ready_low_cycles", 32'(n), 32'(MD + 1));
        check("mult_operands_stable", 32'(unstable), 32'd0);
        drain();

        // flush at BUSY cycle 10, then a normal add
        send(5'b00110, 32'd6, 32'd7, 5'd0, 5'd8, 32'd0, 5'd0, 3'd0, 1'b0);
        repeat (9) begin @(posedge clock); #1; end
        in_flush = 1'b1;
        @(posedge clock); #1;
        in_flush = 1'b0;
        check("flush_ready", 32'(in_ready), 32'd1);
        check("flush_state_idle", 32'(fsm_state), 32'(IDLE));
        send(5'b00000, 32'd2, 32'd3, 5'd0, 5'd3, 32'd5, 5'd3, 3'd0, 1'b1);
        drain();
        repeat (MD + 5) @(posedge clock);
        #1;

        // flush beats a simultaneous accept
        in_valid = 1'b1; in_opcode = 5'b00110; in_a = 32'd9; in_b = 32'd9; in_flush = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0; in_flush = 1'b0;
        check("flush_prio_ready", 32'(in_ready), 32'd1);

        // flush on the capture edge kills a single-cycle result
        send(5'b00000, 32'd1, 32'd1, 5'd0, 5'd2, 32'd0, 5'd0, 3'd0, 1'b0);
        in_flush = 1'b1;
        @(posedge clock); #1;
        in_flush = 1'b0;
        repeat (4) @(posedge clock);
        #1;

        // asynchronous reset in the middle of a div
        send(5'b00111, 32'd100, 32'd3, 5'd0, 5'd14, 32'd0, 5'd0, 3'd0, 1'b0);
        repeat (5) begin @(posedge clock); #1; end
        #2;
        reset = 1'b1;
        #1;
        check("arst_alu_a", alu_a, 32'd0);
        check("arst_alu_b", alu_b, 32'd0);
        check("arst_alu_op", 32'(alu_opcode), 32'd0);
        check("arst_out_result", out_result, 32'd0);
        check("arst_out_rd", 32'(out_rd), 32'd0);
        check("arst_out_exc", 32'(out_exc), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (MD + 10) @(posedge clock);
        #1;

        send(5'b00011, 32'hA000, 32'h000B, 5'd0, 5'd17, 32'hA00B, 5'd17, 3'd0, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multdiv_sequencer.md
MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 SHALL have parameter MD_CYCLES, default 34, the number of cycles ALU operands are held stable for mult/div.
REQ-002 SHALL have parameter RSTATUS_REG, default 30, the register index that receives exception codes.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operation offered from the D/X stage.
REQ-006 in_ready  output  1  sequencer can accept; low means stall the front end.
REQ-007 in_opcode  input  5  ALU opcode: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll, 00101 sra, 00110 mult, 00111 div.
REQ-008 in_shamt  input  5  shift amount.
REQ-009 in_rd  input  5  destination register.
REQ-010 in_a, in_b  input  32 each  operands.
REQ-011 in_flush  input  1  cancel any held or in-flight op.
REQ-012 alu_opcode, alu_shamt  output  5 each  registered, to ALU ctrl_ALUopcode and ctrl_shiftamt.
REQ-013 alu_a, alu_b  output  32 each  registered, to ALU operand inputs.
REQ-014 alu_result  input  32  ALU data_result.
REQ-015 alu_overflow  input  1  ALU overflow.
REQ-016 out_valid  output  1  one-cycle pulse; result and destination are valid.
REQ-017 out_result  output  32  writeback data.
REQ-018 out_rd  output  5  writeback register.
REQ-019 out_exc  output  3  exception code, 0 = none.

Function
REQ-020 SHALL use FSM states IDLE, BUSY, DONE.
REQ-021 in_ready SHALL be 1 in IDLE and 0 in BUSY and DONE.
REQ-022 An op SHALL be accepted on an edge where in_valid && in_ready && !in_flush; the accept loads the alu_* registers, in_rd and the op class.
REQ-023 Single-cycle ops (opcodes 00000–00101, and reserved opcodes 01000–11111) SHALL stay in IDLE.
REQ-024 For single-cycle ops, alu_result and alu_overflow SHALL be captured at the edge after the accept edge, giving out_valid 2 edges after acceptance.
REQ-025 Back-to-back single-cycle ops SHALL sustain a throughput of one per cycle.
REQ-026 mult/div SHALL move IDLE->BUSY on accept and load the counter with MD_CYCLES-1.
REQ-027 In BUSY the counter SHALL decrement each cycle, and alu_* SHALL remain unchanged.
REQ-028 When the counter reaches 0 in BUSY, the sequencer SHALL capture the result and go to DONE.
REQ-029 DONE SHALL assert out_valid for one cycle and return to IDLE.
REQ-030 mult/div latency from accept edge to out_valid SHALL be MD_CYCLES+1 edges.
REQ-031 Exception codes on alu_overflow SHALL be: add=1, sub=3, mult=4, div=5 (div by zero included); and/or/sll/sra/reserved SHALL give 0.
REQ-032 When out_exc != 0, out_rd SHALL be RSTATUS_REG and out_result SHALL be out_exc zero-extended; otherwise out_rd = captured rd and out_result = alu_result.
REQ-033 in_flush SHALL force IDLE, clear the counter, and suppress any pending out_valid, including the captured single-cycle result.
REQ-034 in_flush SHALL take priority over a simultaneous accept.
REQ-035 out_valid, out_result, out_rd and out_exc SHALL be registered outputs.

Reset
REQ-036 Reset SHALL force state IDLE, counter 0, out_valid 0, out_result 0, out_rd 0, out_exc 0, alu_a/alu_b 0, alu_opcode/alu_shamt 0.
REQ-037 Reset asserted mid-BUSY SHALL abandon the op with no out_valid.
REQ-038 The first accept SHALL be possible on the first edge after reset deasserts.

Structure
REQ-039 A shared package SHALL hold the opcode constants, exception codes, state encodings, MD_CYCLES default and RSTATUS_REG.
REQ-040 One sub-module, md_cycle_counter (load, decrement, zero flag), SHALL implement the BUSY counter.

Verification
REQ-041 Test: add 0x7FFFFFFF + 1, rd=5 -> out_valid 2 edges later, out_rd=30, out_result=1, out_exc=1.
REQ-042 Test: sub 10-3 rd=4, then and 0xF0F0&0xFF00 rd=6 on consecutive cycles -> consecutive pulses: 7 to r4, then 0xF000 to r6, out_exc=0.
REQ-043 Test: mult 6*7 rd=8 -> in_ready low for MD_CYCLES+1 cycles, alu_a/alu_b stable throughout, out_valid after MD_CYCLES+1 edges with 42 to r8.
REQ-044 Test: div 5/0 -> out_rd=30, out_result=5, out_exc=5.
REQ-045 Test: in_flush at BUSY cycle 10 of a mult -> no out_valid, in_ready=1 next cycle, new add accepted and completes normally.
REQ-046 Test: reset pulse mid-div -> all outputs 0 immediately (asynchronous), no out_valid after release.
